// File: rtl/alu_raxs.sv
// rtl/alu_raxs.sv - N-bit ALU with registered active-low seven-segment outputs (optional divider: ALU_RAXS_DIV_EN)
module alu_raxs #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A_num,
  input  logic [N-1:0] B_num,
  input  logic [3:0]   operation,
  output logic [6:0]   seg1,
  output logic [6:0]   seg2,
  output logic [6:0]   result_seg
);

  // Shift amounts at or beyond the operand width clear the result.
  localparam logic [N-1:0] SHIFT_LIMIT = N'(N);
  localparam logic [N-1:0] ONE         = N'(1);

  // All-off pattern shown while in reset.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_MOD = 4'b0100,
    OP_AND = 4'b0101,
    OP_OR  = 4'b0110,
    OP_XOR = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001,
    OP_NOT = 4'b1010,
    OP_INC = 4'b1011,
    OP_DEC = 4'b1100
  } op_t;

  logic [N-1:0] result;
  logic [6:0]   seg1_next;
  logic [6:0]   seg2_next;
  logic [6:0]   result_seg_next;

  // Active-low hex digit, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // ALU: every operation wraps to N bits; unused and reserved opcodes give 0.
  always_comb begin
    result = '0;
    case (operation)
      OP_ADD: result = A_num + B_num;
      OP_SUB: result = A_num - B_num;
      OP_MUL: result = A_num * B_num;
`ifdef ALU_RAXS_DIV_EN
      OP_DIV: result = (B_num == '0) ? '1 : A_num / B_num;
      OP_MOD: result = (B_num == '0) ? '1 : A_num % B_num;
`endif
      OP_AND: result = A_num & B_num;
      OP_OR:  result = A_num | B_num;
      OP_XOR: result = A_num ^ B_num;
      OP_SHL: result = (B_num >= SHIFT_LIMIT) ? '0 : (A_num << B_num);
      OP_SHR: result = (B_num >= SHIFT_LIMIT) ? '0 : (A_num >> B_num);
      OP_NOT: result = ~A_num;
      OP_INC: result = A_num + ONE;
      OP_DEC: result = A_num - ONE;
      default: result = '0;
    endcase
  end

  // Decode the low nibble of each displayed value ahead of the output register.
  always_comb begin
    seg1_next       = hex_to_seg(A_num[3:0]);
    seg2_next       = hex_to_seg(B_num[3:0]);
    result_seg_next = hex_to_seg(result[3:0]);
  end

  // Single output register stage; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg1       <= SEG_BLANK;
      seg2       <= SEG_BLANK;
      result_seg <= SEG_BLANK;
    end else begin
      seg1       <= seg1_next;
      seg2       <= seg2_next;
      result_seg <= result_seg_next;
    end
  end

endmodule

// File: tb/tb_alu_raxs.sv
// tb/tb_alu_raxs.sv - directed self-checking bench for alu_raxs (N=4)
module tb_alu_raxs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] A_num = '0;
  logic [3:0] B_num = '0;
  logic [3:0] operation = '0;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] result_seg;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] res;
    string      name;
  } vec_t;

  alu_raxs #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .A_num      (A_num),
    .B_num      (B_num),
    .operation  (operation),
    .seg1       (seg1),
    .seg2       (seg2),
    .result_seg (result_seg)
  );

  always #5 clk = ~clk;

  // Drive between edges, then sample 1 time unit after the next rising edge.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    @(negedge clk);
    A_num = a;
    B_num = b;
    operation = op;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vectors(input vec_t v [$]);
    logic [20:0] exp;
    foreach (v[i]) begin
      apply(v[i].a, v[i].b, v[i].op);
      exp = {SEG[v[i].a], SEG[v[i].b], SEG[v[i].res]};
      n_cmp++;
      if ({seg1, seg2, result_seg} !== exp) begin
        n_bad++;
        $display("FAIL %s: got %b_%b_%b expected %b_%b_%b", v[i].name,
                 seg1, seg2, result_seg, exp[20:14], exp[13:7], exp[6:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    A_num = 4'hF; B_num = 4'h3; operation = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({seg1, seg2, result_seg} !== {BLANK, BLANK, BLANK}) begin
      n_bad++;
      $display("FAIL reset_blank: got %b_%b_%b expected all ones", seg1, seg2, result_seg);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith();
    vec_t v [$];
    v = '{
      '{4'hF, 4'h3, 4'b0001, 4'hC, "sub_15_3"},
      '{4'h3, 4'h1, 4'b0001, 4'h2, "sub_3_1"},
      '{4'hF, 4'h3, 4'b0000, 4'h2, "add_wrap"},
      '{4'h0, 4'h7, 4'b1100, 4'hF, "dec_wrap"},
      '{4'hF, 4'h2, 4'b1011, 4'h0, "inc_wrap"},
      '{4'h5, 4'h3, 4'b0010, 4'hF, "mul_5_3"},
      '{4'h6, 4'h3, 4'b0010, 4'h2, "mul_wrap"},
      '{4'h2, 4'h5, 4'b0001, 4'hD, "sub_borrow"}
    };
    run_vectors(v);
  endtask

  task automatic test_logic();
    vec_t v [$];
    v = '{
      '{4'hC, 4'hA, 4'b0101, 4'h8, "and"},
      '{4'hC, 4'hA, 4'b0110, 4'hE, "or"},
      '{4'hC, 4'hA, 4'b0111, 4'h6, "xor"},
      '{4'h5, 4'h0, 4'b1010, 4'hA, "not"}
    };
    run_vectors(v);
  endtask

  task automatic test_shift();
    vec_t v [$];
    v = '{
      '{4'h3, 4'h2, 4'b1000, 4'hC, "shl_3_2"},
      '{4'h8, 4'h5, 4'b1001, 4'h0, "shr_over"},
      '{4'h8, 4'h3, 4'b1001, 4'h1, "shr_8_3"},
      '{4'h1, 4'h4, 4'b1000, 4'h0, "shl_eq_n"},
      '{4'hF, 4'h4, 4'b1001, 4'h0, "shr_eq_n"},
      '{4'h9, 4'h0, 4'b1000, 4'h9, "shl_zero"}
    };
    run_vectors(v);
  endtask

  task automatic test_div();
    vec_t v [$];
`ifdef ALU_RAXS_DIV_EN
    v = '{
      '{4'hF, 4'h3, 4'b0011, 4'h5, "div_15_3"},
      '{4'hF, 4'h3, 4'b0100, 4'h0, "mod_15_3"},
      '{4'hE, 4'h4, 4'b0100, 4'h2, "mod_14_4"},
      '{4'hF, 4'h0, 4'b0011, 4'hF, "div_by_zero"},
      '{4'h6, 4'h0, 4'b0100, 4'hF, "mod_by_zero"}
    };
`else
    v = '{
      '{4'hF, 4'h3, 4'b0011, 4'h0, "div_disabled"},
      '{4'hF, 4'h3, 4'b0100, 4'h0, "mod_disabled"},
      '{4'hF, 4'h0, 4'b0011, 4'h0, "div0_disabled"}
    };
`endif
    run_vectors(v);
  endtask

  task automatic test_reserved();
    vec_t v [$];
    v = '{
      '{4'h7, 4'h2, 4'b1110, 4'h0, "rsvd_1110"},
      '{4'h7, 4'h2, 4'b1101, 4'h0, "rsvd_1101"},
      '{4'hF, 4'hF, 4'b1111, 4'h0, "rsvd_1111"}
    };
    run_vectors(v);
  endtask

  task automatic test_hold_between_edges();
    apply(4'h4, 4'h1, 4'b0000);
    @(negedge clk);
    A_num = 4'h9; B_num = 4'h9; operation = 4'b0110;
    #2;
    n_cmp++;
    if ({seg1, seg2, result_seg} !== {SEG[4], SEG[1], SEG[5]}) begin
      n_bad++;
      $display("FAIL hold_between_edges: got %b_%b_%b expected %b_%b_%b",
               seg1, seg2, result_seg, SEG[4], SEG[1], SEG[5]);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({seg1, seg2, result_seg} !== {SEG[9], SEG[9], SEG[9]}) begin
      n_bad++;
      $display("FAIL update_next_edge: got %b_%b_%b expected %b_%b_%b",
               seg1, seg2, result_seg, SEG[9], SEG[9], SEG[9]);
    end
  endtask

  task automatic test_mid_reset();
    apply(4'h7, 4'h9, 4'b0000);
    n_cmp++;
    if ({seg1, seg2, result_seg} !== {SEG[7], SEG[9], SEG[0]}) begin
      n_bad++;
      $display("FAIL pre_reset: got %b_%b_%b expected %b_%b_%b",
               seg1, seg2, result_seg, SEG[7], SEG[9], SEG[0]);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({seg1, seg2, result_seg} !== {BLANK, BLANK, BLANK}) begin
      n_bad++;
      $display("FAIL async_reset: got %b_%b_%b expected all ones", seg1, seg2, result_seg);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({seg1, seg2, result_seg} !== {BLANK, BLANK, BLANK}) begin
      n_bad++;
      $display("FAIL reset_held: got %b_%b_%b expected all ones", seg1, seg2, result_seg);
    end
    @(negedge clk);
    A_num = 4'h2; B_num = 4'h4; operation = 4'b0000;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({seg1, seg2, result_seg} !== {BLANK, BLANK, BLANK}) begin
      n_bad++;
      $display("FAIL release_before_edge: got %b_%b_%b expected all ones", seg1, seg2, result_seg);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({seg1, seg2, result_seg} !== {SEG[2], SEG[4], SEG[6]}) begin
      n_bad++;
      $display("FAIL first_edge_after_reset: got %b_%b_%b expected %b_%b_%b",
               seg1, seg2, result_seg, SEG[2], SEG[4], SEG[6]);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [$];
    v = '{
      '{4'hA, 4'h5, 4'b0000, 4'hF, "b2b_add"},
      '{4'hB, 4'hD, 4'b0111, 4'h6, "b2b_xor"},
      '{4'h1, 4'h1, 4'b1100, 4'h0, "b2b_dec"},
      '{4'hE, 4'h1, 4'b1001, 4'h7, "b2b_shr"}
    };
    run_vectors(v);
  endtask

  initial begin
    fork
      begin
        #20000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_div();
    test_reserved();
    test_hold_between_edges();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
